// File: rtl/fir_filter_param_if.sv
// Stream and coefficient-load signals of fir_filter_param, bundled for the
// filter (slave) and the block that feeds it and consumes its results (master).
interface fir_filter_param_if #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int OUT_W  = 8
);
  // Handshake: in_valid marks in_data as a new sample for exactly one cycle.
  // There is no ready in either direction: the filter takes a sample on every
  // cycle in_valid is high, and the consumer must accept y on every cycle
  // out_valid is high.
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              coef_wr;
  logic [3:0]        coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic [OUT_W-1:0]  y;
  logic              sat_flag;

  modport master (
    output in_valid, in_data, coef_wr, coef_addr, coef_data,
    input  out_valid, y, sat_flag
  );

  modport slave (
    input  in_valid, in_data, coef_wr, coef_addr, coef_data,
    output out_valid, y, sat_flag
  );
endinterface

// File: rtl/fir_filter_param.sv
// Streaming direct-form FIR filter: TAPS-deep delay line, writable coefficients,
// registered products then registered sum. Define FIR_SAT_EN to saturate y.
module fir_filter_param #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 3,
  parameter int OUT_W  = 8
) (
  input logic               clk,
  input logic               reset,
  fir_filter_param_if.slave bus
);

  localparam int P_W = DATA_W + COEF_W;
  localparam int S_W = P_W + $clog2(TAPS);
`ifdef FIR_SAT_EN
  localparam int ACC_W = S_W;
`else
  // Wrapping output only needs the low OUT_W bits, and sums are exact modulo 2^OUT_W.
  localparam int ACC_W = OUT_W;
`endif

  logic [DATA_W-1:0] x_q    [1:TAPS-1];
  logic [COEF_W-1:0] h_q    [TAPS];
  logic [P_W-1:0]    prod_q [TAPS];
  logic              v1_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  y_q;
  logic              sat_q;

  logic [ACC_W-1:0]  sum;
  logic [OUT_W-1:0]  y_next;
  logic              sat_next;

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum = sum + ACC_W'(prod_q[i]);
    end
  end

`ifdef FIR_SAT_EN
  generate
    if (ACC_W > OUT_W) begin : g_ovf
      always_comb begin
        y_next   = sum[OUT_W-1:0];
        sat_next = 1'b0;
        if (|sum[ACC_W-1:OUT_W]) begin
          y_next   = '1;
          sat_next = 1'b1;
        end
      end
    end else begin : g_fit
      always_comb begin
        y_next   = sum;
        sat_next = 1'b0;
      end
    end
  endgenerate
`else
  assign y_next   = sum;
  assign sat_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < TAPS; i++) x_q[i] <= '0;
      for (int i = 0; i < TAPS; i++) begin
        h_q[i]    <= '0;
        prod_q[i] <= '0;
      end
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      // Products read h_q before any same-edge coefficient write lands.
      if (bus.in_valid) begin
        prod_q[0] <= P_W'(bus.in_data) * P_W'(h_q[0]);
        for (int i = 1; i < TAPS; i++) begin
          prod_q[i] <= P_W'(x_q[i]) * P_W'(h_q[i]);
        end
        x_q[1] <= bus.in_data;
        for (int i = 2; i < TAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      for (int i = 0; i < TAPS; i++) begin
        if (bus.coef_wr && bus.coef_addr == 4'(i)) h_q[i] <= bus.coef_data;
      end
      out_valid_q <= v1_q;
      if (v1_q) begin
        y_q   <= y_next;
        sat_q <= sat_next;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: directed scenarios plus random traffic, all
// checked against an arithmetic model of the filter kept in this file.
module tb_fir_filter_param;

  localparam int DATA_W = 4;
  localparam int COEF_W = 4;
  localparam int TAPS   = 3;
  localparam int OUT_W  = 8;
  localparam int Y_MAX  = (1 << OUT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fir_filter_param_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) bus ();

  fir_filter_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: coefficients and previous samples (index i = x[i]).
  int h_m    [TAPS];
  int hist_m [TAPS];
  // Scoreboard entries {valid, sat, y}, one per clock edge.
  logic [OUT_W+1:0] exp_q[$];
  logic [OUT_W-1:0] held_y;
  logic             held_sat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      h_m[i]    = 0;
      hist_m[i] = 0;
    end
    exp_q.delete();
    held_y   = '0;
    held_sat = 1'b0;
    // Nothing is in flight right after reset, so the first edge yields no output.
    exp_q.push_back('0);
  endtask

  task automatic check_out();
    logic [OUT_W+1:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("out_valid", 32'(bus.out_valid), 32'(e[OUT_W+1]));
      if (e[OUT_W+1]) begin
        held_y   = e[OUT_W-1:0];
        held_sat = e[OUT_W];
      end
      check("y", 32'(bus.y), 32'(held_y));
      check("sat_flag", 32'(bus.sat_flag), 32'(held_sat));
    end
  endtask

  // One clock: apply inputs at the falling edge, let the rising edge take
  // them, then compare outputs at the next falling edge.
  task automatic step(input bit v, input int d, input bit wr, input int addr, input int cd);
    int full;
    logic [OUT_W-1:0] ey;
    logic es;
    bus.in_valid  = v;
    bus.in_data   = DATA_W'(d);
    bus.coef_wr   = wr;
    bus.coef_addr = 4'(addr);
    bus.coef_data = COEF_W'(cd);
    if (v) begin
      full = d * h_m[0];
      for (int i = 1; i < TAPS; i++) full += hist_m[i] * h_m[i];
`ifdef FIR_SAT_EN
      if (full > Y_MAX) begin
        ey = '1;
        es = 1'b1;
      end else begin
        ey = OUT_W'(full);
        es = 1'b0;
      end
`else
      ey = OUT_W'(full % (Y_MAX + 1));
      es = 1'b0;
`endif
      exp_q.push_back({1'b1, es, ey});
      for (int i = TAPS - 1; i >= 2; i--) hist_m[i] = hist_m[i-1];
      hist_m[1] = d;
    end else begin
      exp_q.push_back('0);
    end
    if (wr && addr < TAPS) h_m[addr] = cd;
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2);
    step(1'b0, 0, 1'b1, 0, c0);
    step(1'b0, 0, 1'b1, 1, c1);
    step(1'b0, 0, 1'b1, 2, c2);
  endtask

  task automatic flush_zero();
    for (int i = 0; i < TAPS; i++) step(1'b1, 0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic impulse();
    step(1'b1, 1, 1'b0, 0, 0);
    for (int i = 0; i < TAPS + 1; i++) step(1'b1, 0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_wr   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_y", 32'(bus.y), 32'd0);
    check("reset_sat_flag", 32'(bus.sat_flag), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Impulse with h = {1,2,3}
    set_coefs(1, 2, 3);
    impulse();

    // Stall: sample 1, three idle cycles, then two zero samples
    step(1'b1, 1, 1'b0, 0, 0);
    repeat (3) step(1'b0, 0, 1'b0, 0, 0);
    step(1'b1, 0, 1'b0, 0, 0);
    step(1'b1, 0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);

    // Overflow: all-15 coefficients and samples
    set_coefs(15, 15, 15);
    repeat (3) step(1'b1, 15, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
    flush_zero();

    // Coefficient write on the same edge as a sample
    set_coefs(1, 1, 1);
    repeat (3) step(1'b1, 2, 1'b0, 0, 0);
    step(1'b1, 2, 1'b1, 0, 3);
    step(1'b1, 2, 1'b0, 0, 0);
    step(1'b0, 0, 1'b0, 0, 0);
    flush_zero();

    // Out-of-range coefficient address is ignored
    set_coefs(1, 2, 3);
    step(1'b0, 0, 1'b1, 5, 9);
    step(1'b0, 0, 1'b1, 15, 7);
    impulse();

    // Random traffic with stalls and coefficient writes (some out of range)
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, (1 << DATA_W) - 1)),
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4)),
           int'($urandom_range(0, (1 << COEF_W) - 1)));
    end

    // Reset mid-stream with samples in flight
    set_coefs(7, 5, 3);
    step(1'b1, 9, 1'b0, 0, 0);
    step(1'b1, 11, 1'b0, 0, 0);
    step(1'b1, 13, 1'b0, 0, 0);
    bus.in_valid = 1'b0;
    bus.coef_wr  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_y", 32'(bus.y), 32'd0);
    check("async_reset_sat_flag", 32'(bus.sat_flag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    impulse();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
